// File: rtl/regfile_pkg.sv
// Shared widths, the register-zero index, the operand bundle type and the
// operand select helper used by the operand-fetch stage.
package regfile_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NREGS  = 1 << ADDR_W;
   localparam int TAG_W  = 4;

   localparam logic [ADDR_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic [DATA_W-1:0] op1;
      logic [DATA_W-1:0] op2;
      logic [ADDR_W-1:0] rd;
      logic              rd_we;
      logic [TAG_W-1:0]  tag;
   } operand_bundle_t;

   // r0 reads zero; otherwise a same-cycle writeback beats the stale RF read.
   function automatic logic [DATA_W-1:0] sel_operand(
      input logic [ADDR_W-1:0] r,
      input logic [DATA_W-1:0] rdata,
      input logic              wb_hit,
      input logic [DATA_W-1:0] wdata
   );
      if (r == REG_ZERO)
         return '0;
      else if (wb_hit)
         return wdata;
      else
         return rdata;
   endfunction

endpackage

// File: rtl/regfile_operand_fetch_if.sv
// Decode/RF/writeback/execute signal bundle of the operand-fetch stage.
// slave is the fetch stage itself, master is whatever surrounds it.
interface regfile_operand_fetch_if;
   import regfile_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_rs1;
   logic [ADDR_W-1:0] in_rs2;
   logic [ADDR_W-1:0] in_rd;
   logic              in_rd_we;
   logic [TAG_W-1:0]  in_tag;

   logic [ADDR_W-1:0] rf_raddr1;
   logic [ADDR_W-1:0] rf_raddr2;
   logic [DATA_W-1:0] rf_rdata1;
   logic [DATA_W-1:0] rf_rdata2;

   logic              wb_we;
   logic [ADDR_W-1:0] wb_waddr;
   logic [DATA_W-1:0] wb_wdata;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_op1;
   logic [DATA_W-1:0] out_op2;
   logic [ADDR_W-1:0] out_rd;
   logic              out_rd_we;
   logic [TAG_W-1:0]  out_tag;

   logic [NREGS-1:0]  busy_mask;

   modport slave (
      input  in_valid, in_rs1, in_rs2, in_rd, in_rd_we, in_tag,
      input  rf_rdata1, rf_rdata2,
      input  wb_we, wb_waddr, wb_wdata,
      input  out_ready,
      output in_ready, rf_raddr1, rf_raddr2,
      output out_valid, out_op1, out_op2, out_rd, out_rd_we, out_tag,
      output busy_mask
   );

   modport master (
      output in_valid, in_rs1, in_rs2, in_rd, in_rd_we, in_tag,
      output rf_rdata1, rf_rdata2,
      output wb_we, wb_waddr, wb_wdata,
      output out_ready,
      input  in_ready, rf_raddr1, rf_raddr2,
      input  out_valid, out_op1, out_op2, out_rd, out_rd_we, out_tag,
      input  busy_mask
   );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue of a
// writing instruction, cleared by writeback, set wins on a same-index tie.
// Provides pend() lookups for three indices (rs1, rs2, rd).
// Macro RF_WB_BYPASS_EN: when defined, a same-cycle writeback hides the
// pending bit of its index so the consumer can issue with the forwarded value.
module rf_scoreboard
   import regfile_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   set_i,
   input  logic [ADDR_W-1:0]      set_idx_i,
   input  logic                   clr_i,
   input  logic [ADDR_W-1:0]      clr_idx_i,
   input  logic [2:0][ADDR_W-1:0] look_idx_i,
   output logic [2:0]             pend_o,
   output logic [NREGS-1:0]       busy_o
);

   logic [NREGS-1:0] busy_q, busy_d;

   // Next busy vector: clear first so a concurrent set of the same index wins.
   always_comb begin
      busy_d = busy_q;
      if (clr_i && clr_idx_i != REG_ZERO)
         busy_d[clr_idx_i] = 1'b0;
      if (set_i && set_idx_i != REG_ZERO)
         busy_d[set_idx_i] = 1'b1;
      busy_d[0] = 1'b0;
   end

   // Busy bit register, wiped by async reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         busy_q <= '0;
      else
         busy_q <= busy_d;
   end

   for (genvar k = 0; k < 3; k++) begin : g_look
      logic hit;
`ifdef RF_WB_BYPASS_EN
      assign hit = clr_i && (clr_idx_i == look_idx_i[k]) && (look_idx_i[k] != REG_ZERO);
`else
      assign hit = 1'b0;
`endif
      assign pend_o[k] = (look_idx_i[k] != REG_ZERO) && busy_q[look_idx_i[k]] && !hit;
   end

   assign busy_o = busy_q;

endmodule

// File: rtl/regfile_operand_fetch.sv
// Operand fetch between decode and execute: drives RF read addresses,
// stalls on pending writes, forwards same-cycle writeback, and holds the
// operand bundle in a one-deep valid/ready output register.
// Macro RF_WB_BYPASS_EN enables same-cycle writeback forwarding; without it
// a source written back this cycle stalls one more cycle and reads the RF.
module regfile_operand_fetch
   import regfile_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst_n,
   regfile_operand_fetch_if.slave        bus_if
);

   operand_bundle_t out_q, out_d;
   logic            out_valid_q, out_valid_d;
   logic [2:0]      pend;
   logic            hazard, accept, set_busy;
   logic            hit1, hit2;

   assign bus_if.rf_raddr1 = bus_if.in_rs1;
   assign bus_if.rf_raddr2 = bus_if.in_rs2;

`ifdef RF_WB_BYPASS_EN
   assign hit1 = bus_if.wb_we && (bus_if.wb_waddr == bus_if.in_rs1) && (bus_if.in_rs1 != REG_ZERO);
   assign hit2 = bus_if.wb_we && (bus_if.wb_waddr == bus_if.in_rs2) && (bus_if.in_rs2 != REG_ZERO);
`else
   assign hit1 = 1'b0;
   assign hit2 = 1'b0;
`endif

   rf_scoreboard u_sb (
      .clk        (clk),
      .rst_n      (rst_n),
      .set_i      (set_busy),
      .set_idx_i  (bus_if.in_rd),
      .clr_i      (bus_if.wb_we),
      .clr_idx_i  (bus_if.wb_waddr),
      .look_idx_i ({bus_if.in_rd, bus_if.in_rs2, bus_if.in_rs1}),
      .pend_o     (pend),
      .busy_o     (bus_if.busy_mask)
   );

   assign hazard          = pend[0] || pend[1] || (bus_if.in_rd_we && pend[2]);
   assign bus_if.in_ready = (!out_valid_q || bus_if.out_ready) && !hazard;
   assign accept          = bus_if.in_valid && bus_if.in_ready;
   assign set_busy        = accept && bus_if.in_rd_we;

   // Output register next state: load on accept, drop valid on bare consume.
   always_comb begin
      out_d       = out_q;
      out_valid_d = out_valid_q;
      if (accept) begin
         out_d.op1   = sel_operand(bus_if.in_rs1, bus_if.rf_rdata1, hit1, bus_if.wb_wdata);
         out_d.op2   = sel_operand(bus_if.in_rs2, bus_if.rf_rdata2, hit2, bus_if.wb_wdata);
         out_d.rd    = bus_if.in_rd;
         out_d.rd_we = bus_if.in_rd_we;
         out_d.tag   = bus_if.in_tag;
         out_valid_d = 1'b1;
      end else if (out_valid_q && bus_if.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Output pipeline register; reset drops any in-flight bundle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus_if.out_valid = out_valid_q;
   assign bus_if.out_op1   = out_q.op1;
   assign bus_if.out_op2   = out_q.op2;
   assign bus_if.out_rd    = out_q.rd;
   assign bus_if.out_rd_we = out_q.rd_we;
   assign bus_if.out_tag   = out_q.tag;

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Directed bench for regfile_operand_fetch: expected bundles are queued at
// issue time and a negedge monitor pops/compares on every output handshake.
module tb_regfile_operand_fetch;
   import regfile_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;
   int   pops  = 0;
   operand_bundle_t exp_q[$];

   always #5 clk = ~clk;

   regfile_operand_fetch_if bus ();

   regfile_operand_fetch dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_if (bus)
   );

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic operand_bundle_t mk(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] rd, input logic we,
                                          input logic [3:0] tag);
      operand_bundle_t e;
      e.op1 = a; e.op2 = b; e.rd = rd; e.rd_we = we; e.tag = tag;
      return e;
   endfunction

   // Scoreboard monitor: every consumed bundle must match the queue head.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         operand_bundle_t got;
         got = {bus.out_op1, bus.out_op2, bus.out_rd, bus.out_rd_we, bus.out_tag};
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out: got %h expected none", got);
         end else begin
            chk("bundle", 80'(got), 80'(exp_q.pop_front()));
            pops++;
         end
      end
   end

   task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic we, input logic [3:0] tag,
                         input logic [31:0] d1, input logic [31:0] d2);
      bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_rd = rd; bus.in_rd_we = we;
      bus.in_tag = tag; bus.rf_rdata1 = d1; bus.rf_rdata2 = d2; bus.in_valid = 1'b1;
   endtask

   // Wait (bounded) for in_ready, queue the expected bundle, then let it clock in.
   task automatic wait_accept(input operand_bundle_t e, input string nm);
      bit ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            exp_q.push_back(e);
            ok = 1'b1;
         end
         @(posedge clk); #1;
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: got no accept expected accept within 20 cycles", nm);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.in_valid = 0; bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_rd = 0; bus.in_rd_we = 0;
      bus.in_tag = 0; bus.rf_rdata1 = 0; bus.rf_rdata2 = 0;
      bus.wb_we = 0; bus.wb_waddr = 0; bus.wb_wdata = 0; bus.out_ready = 1;
      #2;
      chk("rst_out_valid", 80'(bus.out_valid), 80'(0));
      chk("rst_busy", 80'(bus.busy_mask), 80'(0));
      chk("rst_op1", 80'(bus.out_op1), 80'(0));
      chk("rst_tag", 80'(bus.out_tag), 80'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(1);

      // Basic fetch
      set_in(5'd3, 5'd4, 5'd1, 1'b0, 4'd1, 32'h11, 32'h22);
      #1 chk("raddr1", 80'(bus.rf_raddr1), 80'(3));
      chk("raddr2", 80'(bus.rf_raddr2), 80'(4));
      wait_accept(mk(32'h11, 32'h22, 5'd1, 1'b0, 4'd1), "acc_basic");
      @(negedge clk) chk("latency_valid", 80'(bus.out_valid), 80'(1));
      @(posedge clk); #1;

      // r0 reads zero, rd=0 never goes busy
      set_in(5'd0, 5'd2, 5'd0, 1'b1, 4'd2, 32'hDEAD, 32'h33);
      wait_accept(mk(32'h0, 32'h33, 5'd0, 1'b1, 4'd2), "acc_r0");
      @(negedge clk) chk("busy_r0", 80'(bus.busy_mask), 80'(0));
      @(posedge clk); #1;

      // RAW hazard on r5
      set_in(5'd1, 5'd2, 5'd5, 1'b1, 4'd3, 32'h1, 32'h2);
      wait_accept(mk(32'h1, 32'h2, 5'd5, 1'b1, 4'd3), "acc_rd5");
      set_in(5'd5, 5'd0, 5'd6, 1'b0, 4'd4, 32'h5555, 32'h0);
      @(negedge clk);
      chk("busy5", 80'(bus.busy_mask), 80'(32'h20));
      chk("stall5_a", 80'(bus.in_ready), 80'(0));
      @(posedge clk); #1;
      @(negedge clk) chk("stall5_b", 80'(bus.in_ready), 80'(0));
      @(posedge clk); #1;
      bus.wb_we = 1; bus.wb_waddr = 5; bus.wb_wdata = 32'hABCD;
`ifdef RF_WB_BYPASS_EN
      @(negedge clk);
      chk("wb_bypass_ready", 80'(bus.in_ready), 80'(1));
      if (bus.in_ready) exp_q.push_back(mk(32'hABCD, 32'h0, 5'd6, 1'b0, 4'd4));
      @(posedge clk); #1;
      bus.wb_we = 0; bus.in_valid = 0;
`else
      @(negedge clk) chk("wb_nobypass_stall", 80'(bus.in_ready), 80'(0));
      @(posedge clk); #1;
      bus.wb_we = 0; bus.rf_rdata1 = 32'hABCD;
      @(negedge clk);
      chk("wb_late_ready", 80'(bus.in_ready), 80'(1));
      if (bus.in_ready) exp_q.push_back(mk(32'hABCD, 32'h0, 5'd6, 1'b0, 4'd4));
      @(posedge clk); #1;
      bus.in_valid = 0;
`endif
      @(negedge clk) chk("busy_clr5", 80'(bus.busy_mask), 80'(0));
      idle(2);

      // Hold for 3 cycles, then back-to-back
      bus.out_ready = 0;
      set_in(5'd8, 5'd9, 5'd10, 1'b0, 4'd5, 32'h88, 32'h99);
      wait_accept(mk(32'h88, 32'h99, 5'd10, 1'b0, 4'd5), "acc_hold_a");
      set_in(5'd11, 5'd12, 5'd13, 1'b0, 4'd6, 32'hB1, 32'hB2);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_ready", 80'(bus.in_ready), 80'(0));
         chk("hold_valid", 80'(bus.out_valid), 80'(1));
         chk("hold_tag", 80'(bus.out_tag), 80'(5));
         chk("hold_op1", 80'(bus.out_op1), 80'(32'h88));
         @(posedge clk); #1;
      end
      bus.out_ready = 1;
      @(negedge clk) chk("b2b_ready_b", 80'(bus.in_ready), 80'(1));
      if (bus.in_ready) exp_q.push_back(mk(32'hB1, 32'hB2, 5'd13, 1'b0, 4'd6));
      @(posedge clk); #1;
      set_in(5'd14, 5'd15, 5'd16, 1'b0, 4'd7, 32'hC1, 32'hC2);
      @(negedge clk);
      chk("b2b_ready_c", 80'(bus.in_ready), 80'(1));
      chk("b2b_valid", 80'(bus.out_valid), 80'(1));
      if (bus.in_ready) exp_q.push_back(mk(32'hC1, 32'hC2, 5'd16, 1'b0, 4'd7));
      @(posedge clk); #1;
      bus.in_valid = 0;
      idle(2);

      // Set wins over clear of the same index
      set_in(5'd0, 5'd0, 5'd7, 1'b1, 4'd8, 32'h0, 32'h0);
      wait_accept(mk(32'h0, 32'h0, 5'd7, 1'b1, 4'd8), "acc_rd7");
      @(negedge clk) chk("busy7", 80'(bus.busy_mask), 80'(32'h80));
      @(posedge clk); #1;
      bus.wb_we = 1; bus.wb_waddr = 9; bus.wb_wdata = 32'h9;
      @(posedge clk); #1;
      bus.wb_we = 0;
      @(negedge clk) chk("wb_notbusy", 80'(bus.busy_mask), 80'(32'h80));
      @(posedge clk); #1;
`ifndef RF_WB_BYPASS_EN
      bus.wb_we = 1; bus.wb_waddr = 7; bus.wb_wdata = 32'h7;
      @(posedge clk); #1;
      bus.wb_we = 0;
      @(negedge clk) chk("busy7_clr", 80'(bus.busy_mask), 80'(0));
      @(posedge clk); #1;
`endif
      bus.wb_we = 1; bus.wb_waddr = 7; bus.wb_wdata = 32'h77;
      set_in(5'd0, 5'd0, 5'd7, 1'b1, 4'd9, 32'h0, 32'h0);
      @(negedge clk);
      chk("setwins_ready", 80'(bus.in_ready), 80'(1));
      if (bus.in_ready) exp_q.push_back(mk(32'h0, 32'h0, 5'd7, 1'b1, 4'd9));
      @(posedge clk); #1;
      bus.wb_we = 0; bus.in_valid = 0;
      @(negedge clk) chk("setwins_busy", 80'(bus.busy_mask), 80'(32'h80));
      @(posedge clk); #1;
      bus.wb_we = 1; bus.wb_waddr = 7;
      @(posedge clk); #1;
      bus.wb_we = 0;
      idle(2);
      chk("queue_drained", 80'(exp_q.size()), 80'(0));
      chk("pop_count", 80'(pops), 80'(9));

      // Async reset mid-stall
      set_in(5'd1, 5'd2, 5'd5, 1'b1, 4'd10, 32'h1, 32'h2);
      wait_accept(mk(32'h1, 32'h2, 5'd5, 1'b1, 4'd10), "acc_pre_rst");
      bus.out_ready = 0;
      set_in(5'd5, 5'd0, 5'd0, 1'b0, 4'd11, 32'h0, 32'h0);
      @(negedge clk);
      chk("pre_rst_valid", 80'(bus.out_valid), 80'(1));
      chk("pre_rst_busy", 80'(bus.busy_mask), 80'(32'h20));
      chk("pre_rst_stall", 80'(bus.in_ready), 80'(0));
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 80'(bus.out_valid), 80'(0));
      chk("async_rst_busy", 80'(bus.busy_mask), 80'(0));
      exp_q.delete();
      bus.in_valid = 0;
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
